// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multi-cycle MIPS controller: decode inputs,
// memory handshake, write strobes, mux selects and status.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_rdy;
  logic             mem_req;
  logic             mem_we;
  logic             pc_we;
  logic             ir_we;
  logic             reg_we;
  logic [1:0]       npc_sel;
  logic [1:0]       reg_dst;
  logic [1:0]       wd_sel;
  logic [1:0]       alu_op;
  logic             alu_src_b;
  logic             ext_op;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, funct, zero, mem_rdy,
    output mem_req, mem_we, pc_we, ir_we, reg_we,
    output npc_sel, reg_dst, wd_sel, alu_op, alu_src_b, ext_op,
    output state, illegal, instret
  );

  modport slave (
    output opcode, funct, zero, mem_rdy,
    input  mem_req, mem_we, pc_we, ir_we, reg_we,
    input  npc_sel, reg_dst, wd_sel, alu_op, alu_src_b, ext_op,
    input  state, illegal, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory ready handshake, illegal-encoding detection and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned CNT_W           = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_J, I_JAL, I_ILL
  } instr_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_RS   = 2'd3;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_RA   = 2'd2;
  localparam logic [1:0] WD_MDR   = 2'd1;
  localparam logic [1:0] WD_PC    = 2'd2;
  localparam logic [1:0] WD_IMM   = 2'd3;
  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  instr_e           instr;

  logic       retire;
  logic       mem_req, mem_we, pc_we, ir_we, reg_we, illegal;
  logic [1:0] npc_sel, reg_dst, wd_sel, alu_op;
  logic       alu_src_b, ext_op;

  always_comb begin
    instr = I_ILL;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.funct)
          FN_ADDU: instr = I_ADDU;
          FN_SUBU: instr = I_SUBU;
          FN_JR:   instr = I_JR;
          default: instr = I_ILL;
        endcase
      end
      OP_ORI:  instr = I_ORI;
      OP_LW:   instr = I_LW;
      OP_SW:   instr = I_SW;
      OP_BEQ:  instr = I_BEQ;
      OP_LUI:  instr = I_LUI;
      OP_J:    instr = I_J;
      OP_JAL:  instr = I_JAL;
      default: instr = I_ILL;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    illegal   = 1'b0;
    npc_sel   = NPC_SEQ;
    reg_dst   = '0;
    wd_sel    = '0;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_rdy) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          npc_sel = NPC_SEQ;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (instr)
          I_J: begin
            pc_we   = 1'b1;
            npc_sel = NPC_JMP;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          I_JR: begin
            pc_we   = 1'b1;
            npc_sel = NPC_RS;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          I_JAL:   state_d = S_WB;
          I_ILL: begin
            illegal = 1'b1;
            state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (instr)
          I_SUBU: alu_op = ALU_SUB;
          I_ORI: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_OR;
          end
          I_LW, I_SW: begin
            alu_src_b = 1'b1;
            ext_op    = 1'b1;
          end
          I_BEQ: begin
            alu_op  = ALU_SUB;
            pc_we   = bus.zero;
            npc_sel = NPC_BR;
          end
          default: ;
        endcase
        if (instr == I_BEQ) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (instr == I_LW || instr == I_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (instr == I_SW);
        if (bus.mem_rdy) begin
          if (instr == I_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        case (instr)
          I_ADDU, I_SUBU: reg_dst = DST_RD;
          I_LUI:          wd_sel  = WD_IMM;
          I_LW:           wd_sel  = WD_MDR;
          I_JAL: begin
            reg_dst = DST_RA;
            wd_sel  = WD_PC;
            pc_we   = 1'b1;
            npc_sel = NPC_JMP;
          end
          default: ;
        endcase
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase

    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Reset state is FETCH, which would otherwise raise mem_req combinationally
  // while reset is held; gate every decoded output with reset_n.
  assign bus.mem_req   = reset_n & mem_req;
  assign bus.mem_we    = reset_n & mem_we;
  assign bus.pc_we     = reset_n & pc_we;
  assign bus.ir_we     = reset_n & ir_we;
  assign bus.reg_we    = reset_n & reg_we;
  assign bus.illegal   = reset_n & illegal;
  assign bus.npc_sel   = reset_n ? npc_sel : '0;
  assign bus.reg_dst   = reset_n ? reg_dst : '0;
  assign bus.wd_sel    = reset_n ? wd_sel  : '0;
  assign bus.alu_op    = reset_n ? alu_op  : '0;
  assign bus.alu_src_b = reset_n & alu_src_b;
  assign bus.ext_op    = reset_n & ext_op;
  assign bus.state     = state_q;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a default instance (32-bit counter, skip illegal) and
// a 3-bit counter / halt-on-illegal instance share the instruction stream.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BAD = 6'h3F;
  localparam logic [5:0] F_NONE = 6'h00;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_BAD  = 6'h20;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4;

  // strobes {mem_req, mem_we, pc_we, ir_we, reg_we, illegal}
  localparam logic [5:0] K_NONE = 6'b000000;
  localparam logic [5:0] K_FHIT = 6'b101100;
  localparam logic [5:0] K_REQ  = 6'b100000;
  localparam logic [5:0] K_WR   = 6'b110000;
  localparam logic [5:0] K_PC   = 6'b001000;
  localparam logic [5:0] K_RW   = 6'b000010;
  localparam logic [5:0] K_JAL  = 6'b001010;
  localparam logic [5:0] K_ILL  = 6'b000001;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [18:0] ctl;
    logic [31:0] ir;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic [5:0] opcode = OP_R;
  logic [5:0] funct = F_ADDU;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus_a ();
  multicycle_ctrl_if #(.CNT_W(3))  bus_b ();

  assign bus_a.opcode  = opcode;
  assign bus_a.funct   = funct;
  assign bus_a.zero    = zero;
  assign bus_a.mem_rdy = mem_rdy;
  assign bus_b.opcode  = opcode;
  assign bus_b.funct   = funct;
  assign bus_b.zero    = zero;
  assign bus_b.mem_rdy = mem_rdy;

  multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_a (
    .clk(clk), .reset_n(rst_a), .bus(bus_a.master));
  multicycle_ctrl #(.CNT_W(3), .HALT_ON_ILLEGAL(1'b1)) dut_b (
    .clk(clk), .reset_n(rst_b), .bus(bus_b.master));

  // {state, strobes, npc_sel, reg_dst, wd_sel, alu_op, alu_src_b, ext_op}
  logic [18:0] act_a, act_b;
  assign act_a = {bus_a.state, bus_a.mem_req, bus_a.mem_we, bus_a.pc_we, bus_a.ir_we,
                  bus_a.reg_we, bus_a.illegal, bus_a.npc_sel, bus_a.reg_dst, bus_a.wd_sel,
                  bus_a.alu_op, bus_a.alu_src_b, bus_a.ext_op};
  assign act_b = {bus_b.state, bus_b.mem_req, bus_b.mem_we, bus_b.pc_we, bus_b.ir_we,
                  bus_b.reg_we, bus_b.illegal, bus_b.npc_sel, bus_b.reg_dst, bus_b.wd_sel,
                  bus_b.alu_op, bus_b.alu_src_b, bus_b.ext_op};

  // sel = {npc_sel, reg_dst, wd_sel, alu_op}; ae = {alu_src_b, ext_op}
  function automatic vec_t v(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic rdy, input logic [2:0] st, input logic [5:0] stb,
                             input logic [7:0] sel, input logic [1:0] ae,
                             input logic [31:0] ir);
    vec_t r;
    r.op  = op;
    r.fn  = fn;
    r.z   = z;
    r.rdy = rdy;
    r.ctl = {st, stb, sel, ae};
    r.ir  = ir;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t s);
    vec_t e;
    opcode  = s.op;
    funct   = s.fn;
    zero    = s.z;
    mem_rdy = s.rdy;
    exp_q.push_back(s);
    @(negedge clk);
    e = exp_q.pop_front();
    check("ctl", 32'(act_a), 32'(e.ctl));
    check("instret", bus_a.instret, e.ir);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ALU sequence: addu, ori, lui, j
    tbl.push_back(v(OP_R,   F_ADDU, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd0));
    tbl.push_back(v(OP_R,   F_ADDU, 1'b0, 1'b1, SD, K_NONE, 8'h00, 2'b00, 32'd0));
    tbl.push_back(v(OP_R,   F_ADDU, 1'b1, 1'b1, SE, K_NONE, 8'h00, 2'b00, 32'd0));
    tbl.push_back(v(OP_R,   F_ADDU, 1'b0, 1'b1, SW, K_RW,   8'h10, 2'b00, 32'd0));
    tbl.push_back(v(OP_ORI, F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd1));
    tbl.push_back(v(OP_ORI, F_NONE, 1'b0, 1'b1, SD, K_NONE, 8'h00, 2'b00, 32'd1));
    tbl.push_back(v(OP_ORI, F_NONE, 1'b0, 1'b1, SE, K_NONE, 8'h02, 2'b10, 32'd1));
    tbl.push_back(v(OP_ORI, F_NONE, 1'b0, 1'b1, SW, K_RW,   8'h00, 2'b00, 32'd1));
    tbl.push_back(v(OP_LUI, F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd2));
    tbl.push_back(v(OP_LUI, F_NONE, 1'b0, 1'b1, SD, K_NONE, 8'h00, 2'b00, 32'd2));
    tbl.push_back(v(OP_LUI, F_NONE, 1'b0, 1'b1, SE, K_NONE, 8'h00, 2'b00, 32'd2));
    tbl.push_back(v(OP_LUI, F_NONE, 1'b0, 1'b1, SW, K_RW,   8'h0C, 2'b00, 32'd2));
    tbl.push_back(v(OP_J,   F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd3));
    tbl.push_back(v(OP_J,   F_NONE, 1'b0, 1'b1, SD, K_PC,   8'h80, 2'b00, 32'd3));
    // subu, jr
    tbl.push_back(v(OP_R,   F_SUBU, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd4));
    tbl.push_back(v(OP_R,   F_SUBU, 1'b0, 1'b1, SD, K_NONE, 8'h00, 2'b00, 32'd4));
    tbl.push_back(v(OP_R,   F_SUBU, 1'b0, 1'b1, SE, K_NONE, 8'h01, 2'b00, 32'd4));
    tbl.push_back(v(OP_R,   F_SUBU, 1'b0, 1'b1, SW, K_RW,   8'h10, 2'b00, 32'd4));
    tbl.push_back(v(OP_R,   F_JR,   1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd5));
    tbl.push_back(v(OP_R,   F_JR,   1'b0, 1'b1, SD, K_PC,   8'hC0, 2'b00, 32'd5));
    // lw with 2 FETCH and 3 MEM wait cycles; mem_rdy low in DECODE/EXEC/WB is ignored
    tbl.push_back(v(OP_LW,  F_NONE, 1'b0, 1'b0, SF, K_REQ,  8'h00, 2'b00, 32'd6));
    tbl.push_back(v(OP_LW,  F_NONE, 1'b0, 1'b0, SF, K_REQ,  8'h00, 2'b00, 32'd6));
    tbl.push_back(v(OP_LW,  F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd6));
    tbl.push_back(v(OP_LW,  F_NONE, 1'b0, 1'b0, SD, K_NONE, 8'h00, 2'b00, 32'd6));
    tbl.push_back(v(OP_LW,  F_NONE, 1'b0, 1'b0, SE, K_NONE, 8'h00, 2'b11, 32'd6));
    tbl.push_back(v(OP_LW,  F_NONE, 1'b0, 1'b0, SM, K_REQ,  8'h00, 2'b00, 32'd6));
    tbl.push_back(v(OP_LW,  F_NONE, 1'b0, 1'b0, SM, K_REQ,  8'h00, 2'b00, 32'd6));
    tbl.push_back(v(OP_LW,  F_NONE, 1'b0, 1'b0, SM, K_REQ,  8'h00, 2'b00, 32'd6));
    tbl.push_back(v(OP_LW,  F_NONE, 1'b0, 1'b1, SM, K_REQ,  8'h00, 2'b00, 32'd6));
    tbl.push_back(v(OP_LW,  F_NONE, 1'b0, 1'b0, SW, K_RW,   8'h04, 2'b00, 32'd6));
    // sw with one MEM wait
    tbl.push_back(v(OP_SW,  F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd7));
    tbl.push_back(v(OP_SW,  F_NONE, 1'b0, 1'b1, SD, K_NONE, 8'h00, 2'b00, 32'd7));
    tbl.push_back(v(OP_SW,  F_NONE, 1'b0, 1'b1, SE, K_NONE, 8'h00, 2'b11, 32'd7));
    tbl.push_back(v(OP_SW,  F_NONE, 1'b0, 1'b0, SM, K_WR,   8'h00, 2'b00, 32'd7));
    tbl.push_back(v(OP_SW,  F_NONE, 1'b0, 1'b1, SM, K_WR,   8'h00, 2'b00, 32'd7));
    // beq taken then not taken
    tbl.push_back(v(OP_BEQ, F_NONE, 1'b1, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd8));
    tbl.push_back(v(OP_BEQ, F_NONE, 1'b1, 1'b1, SD, K_NONE, 8'h00, 2'b00, 32'd8));
    tbl.push_back(v(OP_BEQ, F_NONE, 1'b1, 1'b1, SE, K_PC,   8'h41, 2'b00, 32'd8));
    tbl.push_back(v(OP_BEQ, F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd9));
    tbl.push_back(v(OP_BEQ, F_NONE, 1'b0, 1'b1, SD, K_NONE, 8'h00, 2'b00, 32'd9));
    tbl.push_back(v(OP_BEQ, F_NONE, 1'b0, 1'b1, SE, K_NONE, 8'h41, 2'b00, 32'd9));
    // jal
    tbl.push_back(v(OP_JAL, F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd10));
    tbl.push_back(v(OP_JAL, F_NONE, 1'b0, 1'b1, SD, K_NONE, 8'h00, 2'b00, 32'd10));
    tbl.push_back(v(OP_JAL, F_NONE, 1'b0, 1'b1, SW, K_JAL,  8'hA8, 2'b00, 32'd10));
    // illegal opcode and illegal R-type funct: skipped, not retired
    tbl.push_back(v(OP_BAD, F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd11));
    tbl.push_back(v(OP_BAD, F_NONE, 1'b0, 1'b1, SD, K_ILL,  8'h00, 2'b00, 32'd11));
    tbl.push_back(v(OP_R,   F_BAD,  1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd11));
    tbl.push_back(v(OP_R,   F_BAD,  1'b0, 1'b1, SD, K_ILL,  8'h00, 2'b00, 32'd11));
    tbl.push_back(v(OP_J,   F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd11));

    // reset held with mem_rdy high
    repeat (3) begin
      @(negedge clk);
      check("rst_ctl_a", 32'(act_a), 32'd0);
      check("rst_instret_a", bus_a.instret, 32'd0);
      check("rst_ctl_b", 32'(act_b), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end
    check("halt_after_table_b", 32'(bus_b.state), 32'd7);

    // 3-bit counter wraps after 8 retires
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(v(OP_J, F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'(i)));
      apply(v(OP_J, F_NONE, 1'b0, 1'b1, SD, K_PC,   8'h80, 2'b00, 32'(i)));
      check("wrap_b", 32'(bus_b.instret), 32'((i + 1) % 8));
    end
    check("wrap_a", bus_a.instret, 32'd9);

    // halt on illegal: no strobes and no exit until reset
    opcode  = OP_BAD;
    funct   = F_NONE;
    mem_rdy = 1'b1;
    @(negedge clk);
    check("halt_fetch_b", 32'(bus_b.state), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("halt_illegal_b", 32'(bus_b.illegal), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      mem_rdy = i[0];
      opcode  = i[0] ? OP_LW : OP_J;
      @(negedge clk);
      check("halt_hold_b", 32'(act_b), 32'h70000);
      @(posedge clk);
      #1;
    end
    check("halt_instret_b", 32'(bus_b.instret), 32'd1);
    mem_rdy = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    check("halt_rst_ctl_b", 32'(act_b), 32'd0);
    check("halt_rst_instret_b", 32'(bus_b.instret), 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(negedge clk);
    check("halt_exit_b", 32'(act_b), 32'h08000);
    @(posedge clk);
    #1;

    // reset during the MEM wait of an sw aborts it with no retire
    do_reset();
    apply(v(OP_J,  F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd0));
    apply(v(OP_J,  F_NONE, 1'b0, 1'b1, SD, K_PC,   8'h80, 2'b00, 32'd0));
    apply(v(OP_SW, F_NONE, 1'b0, 1'b1, SF, K_FHIT, 8'h00, 2'b00, 32'd1));
    apply(v(OP_SW, F_NONE, 1'b0, 1'b1, SD, K_NONE, 8'h00, 2'b00, 32'd1));
    apply(v(OP_SW, F_NONE, 1'b0, 1'b1, SE, K_NONE, 8'h00, 2'b11, 32'd1));
    apply(v(OP_SW, F_NONE, 1'b0, 1'b0, SM, K_WR,   8'h00, 2'b00, 32'd1));
    check("mid_req_before", 32'(bus_a.mem_req), 32'd1);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("mid_req", 32'(bus_a.mem_req), 32'd0);
    check("mid_state", 32'(bus_a.state), 32'd0);
    check("mid_instret", bus_a.instret, 32'd0);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
